// File: rtl/axi_decerr_slv_pkg.sv
// Shared types and constants for the decode-error terminating slave.
// Holds the AXI response code, the burst-length type and the R-channel FSM states.
package axi_decerr_slv_pkg;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [7:0] len_t;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axi_decerr_slv_if.sv
// AXI4 channel bundle seen by the decode-error slave.
// W data/strb and all unused AW/AR attributes are intentionally absent.
interface axi_decerr_slv_if
  import axi_decerr_slv_pkg::*;
#(
  parameter int IdWidth   = 4,
  parameter int DataWidth = 64
);

  logic [IdWidth-1:0]   aw_id;
  logic                 aw_valid;
  logic                 aw_ready;
  logic                 w_last;
  logic                 w_valid;
  logic                 w_ready;
  logic [IdWidth-1:0]   b_id;
  logic [1:0]           b_resp;
  logic                 b_valid;
  logic                 b_ready;
  logic [IdWidth-1:0]   ar_id;
  len_t                 ar_len;
  logic                 ar_valid;
  logic                 ar_ready;
  logic [IdWidth-1:0]   r_id;
  logic [DataWidth-1:0] r_data;
  logic [1:0]           r_resp;
  logic                 r_last;
  logic                 r_valid;
  logic                 r_ready;

  modport master (
    output aw_id, aw_valid, w_last, w_valid, b_ready, ar_id, ar_len, ar_valid, r_ready,
    input  aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready, r_id, r_data, r_resp, r_last,
           r_valid
  );

  modport slave (
    input  aw_id, aw_valid, w_last, w_valid, b_ready, ar_id, ar_len, ar_valid, r_ready,
    output aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready, r_id, r_data, r_resp, r_last,
           r_valid
  );

endinterface

// File: rtl/axi_decerr_slv_fifo.sv
// Small circular FIFO with full/empty/usage flags; works for any Depth >= 1.
// Storage is not reset; only pointers and the occupancy count are.
module axi_decerr_slv_fifo
  import axi_decerr_slv_pkg::*;
#(
  parameter int Width = 4,
  parameter int Depth = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [Width-1:0]        din,
  input  logic                    pop,
  output logic [Width-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(Depth)-1:0] usage
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = cnt_w(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  cnt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CntW'(Depth));
  assign empty = (cnt == '0);
  assign usage = cnt;

  no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/axi_decerr_slv.sv
// Terminating AXI4 slave: every write gets one DECERR B beat, every read len+1 DECERR R beats.
// IDs and RLAST are preserved so the upstream demux sees a protocol-correct completion.
module axi_decerr_slv
  import axi_decerr_slv_pkg::*;
#(
  parameter int          IdWidth   = 4,
  parameter int          DataWidth = 64,
  parameter int          MaxTrans  = 4,
  parameter logic [63:0] RespData  = 64'hBADCAB1E
) (
  input  logic              clk,
  input  logic              rst,
  axi_decerr_slv_if.slave   bus,
  output logic              busy
);

  localparam int CntW = cnt_w(MaxTrans);

  logic                      live;
  logic                      aw_full, aw_empty, aw_pop;
  logic [IdWidth-1:0]        aw_head;
  logic [CntW-1:0]           aw_usage;
  logic                      ar_full, ar_empty, ar_pop;
  logic [IdWidth+7:0]        ar_head;
  logic [CntW-1:0]           ar_usage;
  logic                      b_valid_q, w_open;
  logic [IdWidth-1:0]        b_id_q;
  r_state_e                  state_q, state_d;
  len_t                      beat_cnt_q, beat_cnt_d;
  logic [IdWidth-1:0]        r_id_q, r_id_d;

  // Readies stay low during reset and come up from a flop, never combinationally from rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  assign bus.aw_ready = live && !aw_full;
  assign bus.ar_ready = live && !ar_full;
  assign bus.w_ready  = !aw_empty && !b_valid_q;
  assign aw_pop       = bus.w_valid && bus.w_ready && bus.w_last;

  axi_decerr_slv_fifo #(.Width(IdWidth), .Depth(MaxTrans)) u_aw_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.aw_valid && bus.aw_ready),
    .din   (bus.aw_id),
    .pop   (aw_pop),
    .dout  (aw_head),
    .full  (aw_full),
    .empty (aw_empty),
    .usage (aw_usage)
  );

  axi_decerr_slv_fifo #(.Width(IdWidth + 8), .Depth(MaxTrans)) u_ar_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.ar_valid && bus.ar_ready),
    .din   ({bus.ar_id, bus.ar_len}),
    .pop   (ar_pop),
    .dout  (ar_head),
    .full  (ar_full),
    .empty (ar_empty),
    .usage (ar_usage)
  );

  // B register: w_ready is held off while B is pending, so set and clear never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_id_q    <= '0;
      w_open    <= 1'b0;
    end else begin
      if (bus.w_valid && bus.w_ready) w_open <= !bus.w_last;
      if (aw_pop) begin
        b_valid_q <= 1'b1;
        b_id_q    <= aw_head;
      end else if (bus.b_ready) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  assign bus.b_valid = b_valid_q;
  assign bus.b_id    = b_id_q;
  assign bus.b_resp  = RESP_DECERR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= R_IDLE;
      beat_cnt_q <= '0;
      r_id_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      r_id_q     <= r_id_d;
    end
  end

  // beat_cnt counts remaining beats after the current one, so len=255 never wraps.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    r_id_d     = r_id_q;
    ar_pop     = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (!ar_empty) begin
          ar_pop     = 1'b1;
          beat_cnt_d = ar_head[7:0];
          r_id_d     = ar_head[IdWidth+7:8];
          state_d    = R_BURST;
        end
      end
      R_BURST: begin
        if (bus.r_ready) begin
          if (beat_cnt_q == '0) state_d = R_IDLE;
          else                  beat_cnt_d = beat_cnt_q - 8'd1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign bus.r_valid = (state_q == R_BURST);
  assign bus.r_last  = bus.r_valid && (beat_cnt_q == '0);
  assign bus.r_id    = r_id_q;
  assign bus.r_data  = bus.r_valid ? DataWidth'(RespData) : '0;
  assign bus.r_resp  = RESP_DECERR;

  assign busy = (aw_usage != '0) || (ar_usage != '0) || w_open || b_valid_q ||
                (state_q == R_BURST);

endmodule

// File: tb/tb_axi_decerr_slv.sv
// Scoreboard bench for axi_decerr_slv: expected B/R beats are queued as stimulus is issued
// and retired by a negedge monitor that also checks stability under back-pressure.
module tb_axi_decerr_slv;

  localparam logic [63:0] RESP_DATA = 64'hBADCAB1E;

  typedef struct {
    logic [3:0] id;
    logic       last;
  } rbeat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  axi_decerr_slv_if #(.IdWidth(4), .DataWidth(64)) bus ();

  axi_decerr_slv #(
    .IdWidth(4), .DataWidth(64), .MaxTrans(4), .RespData(RESP_DATA)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [3:0] b_q[$];
  rbeat_t     r_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ready drivers: 0 = always ready, 1 = toggle each cycle, 2 = random.
  int r_mode = 0;
  int b_mode = 0;
  always @(posedge clk) begin
    #1;
    case (r_mode)
      0:       bus.r_ready = 1'b1;
      1:       bus.r_ready = !bus.r_ready;
      default: bus.r_ready = 1'($urandom_range(0, 1));
    endcase
    case (b_mode)
      0:       bus.b_ready = 1'b1;
      1:       bus.b_ready = !bus.b_ready;
      default: bus.b_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic        b_stall = 1'b0, r_stall = 1'b0;
  logic [3:0]  b_prev_id, r_prev_id;
  logic        r_prev_last;
  logic [63:0] r_prev_data;
  logic [3:0]  b_exp;
  rbeat_t      r_exp;

  always @(negedge clk) begin
    if (rst) begin
      b_stall = 1'b0;
      r_stall = 1'b0;
    end else begin
      if (b_stall) begin
        check("b_hold_valid", 64'(bus.b_valid), 64'd1);
        check("b_hold_id", 64'(bus.b_id), 64'(b_prev_id));
      end
      if (bus.b_valid && bus.b_ready) begin
        if (b_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
        else begin
          b_exp = b_q.pop_front();
          check("b_id", 64'(bus.b_id), 64'(b_exp));
          check("b_resp", 64'(bus.b_resp), 64'd3);
        end
      end
      b_stall   = bus.b_valid && !bus.b_ready;
      b_prev_id = bus.b_id;

      if (r_stall) begin
        check("r_hold_valid", 64'(bus.r_valid), 64'd1);
        check("r_hold_id", 64'(bus.r_id), 64'(r_prev_id));
        check("r_hold_last", 64'(bus.r_last), 64'(r_prev_last));
        check("r_hold_data", bus.r_data, r_prev_data);
      end
      if (bus.r_valid && bus.r_ready) begin
        if (r_q.size() == 0) check("r_unexpected", 64'd1, 64'd0);
        else begin
          r_exp = r_q.pop_front();
          check("r_id", 64'(bus.r_id), 64'(r_exp.id));
          check("r_last", 64'(bus.r_last), 64'(r_exp.last));
          check("r_data", bus.r_data, RESP_DATA);
          check("r_resp", 64'(bus.r_resp), 64'd3);
        end
      end
      r_stall     = bus.r_valid && !bus.r_ready;
      r_prev_id   = bus.r_id;
      r_prev_last = bus.r_last;
      r_prev_data = bus.r_data;
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic send_aw(input logic [3:0] id);
    bit done = 0;
    b_q.push_back(id);
    bus.aw_id = id;
    bus.aw_valid = 1'b1;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      done = bus.aw_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("aw_timeout", 64'd0, 64'd1);
    bus.aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic last);
    bit done = 0;
    bus.w_last = last;
    bus.w_valid = 1'b1;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      done = bus.w_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("w_timeout", 64'd0, 64'd1);
    bus.w_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input int len);
    bit done = 0;
    for (int i = 0; i <= len; i++) r_q.push_back('{id: id, last: (i == len)});
    bus.ar_id = id;
    bus.ar_len = 8'(len);
    bus.ar_valid = 1'b1;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      done = bus.ar_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("ar_timeout", 64'd0, 64'd1);
    bus.ar_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (r_q.size() == 0 && b_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(tag, 64'(r_q.size() + b_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bus.aw_id = '0; bus.aw_valid = 1'b0;
    bus.w_last = 1'b0; bus.w_valid = 1'b0;
    bus.ar_id = '0; bus.ar_len = '0; bus.ar_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    check("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    check("rst_w_ready", 64'(bus.w_ready), 64'd0);
    check("rst_b_valid", 64'(bus.b_valid), 64'd0);
    check("rst_r_valid", 64'(bus.r_valid), 64'd0);
    check("rst_ids", 64'({bus.b_id, bus.r_id}), 64'd0);
    check("rst_r_last", 64'(bus.r_last), 64'd0);
    check("rst_r_data", bus.r_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // 1: single write, B at AW+2
    b_mode = 0;
    bus.aw_id = 4'd3; bus.aw_valid = 1'b1; b_q.push_back(4'd3);
    @(negedge clk);
    check("t1_aw_ready", 64'(bus.aw_ready), 64'd1);
    @(posedge clk); #1;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b1; bus.w_last = 1'b1;
    @(negedge clk);
    check("t1_w_ready", 64'(bus.w_ready), 64'd1);
    check("t1_b_early", 64'(bus.b_valid), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    bus.w_valid = 1'b0;
    @(negedge clk);
    check("t1_b_valid", 64'(bus.b_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_b_drop", 64'(bus.b_valid), 64'd0);
    @(posedge clk); #1;
    check("t1_drain", 64'(b_q.size()), 64'd0);

    // 2: AR len=3, first R at AR+2
    r_mode = 0;
    send_ar(4'd5, 3);
    @(negedge clk);
    check("t2_r_lat1", 64'(bus.r_valid), 64'd0);
    @(negedge clk);
    check("t2_r_lat2", 64'(bus.r_valid), 64'd1);
    @(posedge clk); #1;
    wait_drain("t2_drain", 50);

    // 3: toggled r_ready, len=2
    r_mode = 1;
    send_ar(4'd2, 2);
    wait_drain("t3_drain", 50);
    r_mode = 0;

    // 4: MaxTrans+1 AWs with W withheld
    b_mode = 1;
    for (int i = 1; i <= 4; i++) send_aw(4'(i));
    bus.aw_id = 4'd5; bus.aw_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t4_aw_full", 64'(bus.aw_ready), 64'd0);
      check("t4_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    fork
      send_aw(4'd5);
      for (int i = 0; i < 5; i++) send_w(1'b1);
    join
    wait_drain("t4_drain", 100);

    // 5: long read alongside random-backpressure writes
    b_mode = 2;
    fork
      send_ar(4'd6, 255);
      for (int i = 8; i < 14; i++) send_aw(4'(i));
      for (int i = 0; i < 6; i++) begin send_w(1'b0); send_w(1'b1); end
    join
    wait_drain("t5_drain", 1000);
    @(posedge clk); #1;
    check("t5_idle", 64'(busy), 64'd0);

    // 6: reset in the middle of a burst
    b_mode = 0;
    send_ar(4'd7, 5);
    n = 0;
    while (r_q.size() > 5 && n < 100) begin @(posedge clk); n++; end
    #2;
    rst = 1'b1;
    #1;
    check("t6_r_valid", 64'(bus.r_valid), 64'd0);
    check("t6_b_valid", 64'(bus.b_valid), 64'd0);
    check("t6_r_last", 64'(bus.r_last), 64'd0);
    check("t6_ready", 64'({bus.aw_ready, bus.ar_ready}), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    r_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("t6_empty", 64'(busy), 64'd0);
    send_ar(4'd9, 0);
    wait_drain("t6_drain", 50);
    @(posedge clk); #1;
    check("t6_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
